sipo_rx_ctrl: RTL and testbench

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_ctrl_pkg.sv | 13 +
 rtl/sipo_shreg.sv | 24 ++
 rtl/sipo_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receive controller.
package sipo_ctrl_pkg;

   localparam int SIPO_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_HOLD   = 2'd3
   } sipo_state_t;

endpackage

// File: rtl/sipo_shreg.sv
// Right-shifting capture register: serial bit enters the MSB, so the first bit lands in bit 0.
module sipo_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_si,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= {i_si, r_q[WIDTH-1:1]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial word receiver: frame start, gapped bit capture, held word with ready handshake.
// Define SIPO_PARITY_EN to add a trailing even-parity bit and the parity_err check.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; serial input ignored
// ST_SHIFT  | collecting data bits, one per si_valid cycle
// ST_PARITY | waiting for the parity bit (SIPO_PARITY_EN builds only)
// ST_HOLD   | complete word presented until the consumer takes it
module sipo_rx_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             si,
   input  logic             si_valid,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   input  logic             po_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   sipo_state_t      r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_po_valid, w_po_valid_nxt;
   logic             r_busy;
   logic             r_overrun, w_overrun_nxt;
   logic             w_clr, w_shift;
   logic [WIDTH-1:0] w_po;
`ifdef SIPO_PARITY_EN
   logic             r_parity_err, w_parity_err_nxt;
`endif

   sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk  (clk),
      .i_clr(rst | w_clr),
      .i_en (w_shift & ~rst),
      .i_si (si),
      .o_q  (w_po)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_po_valid_nxt = r_po_valid;
      w_overrun_nxt  = r_overrun;
      w_clr          = 1'b0;
      w_shift        = 1'b0;
`ifdef SIPO_PARITY_EN
      w_parity_err_nxt = r_parity_err;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = '0;
               w_clr       = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (start) begin
               w_cnt_nxt = '0;
               w_clr     = 1'b1;
            end else if (si_valid) begin
               w_shift = 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  w_cnt_nxt = CW'(WIDTH);
`ifdef SIPO_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt    = ST_HOLD;
                  w_po_valid_nxt = 1'b1;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         ST_PARITY: begin
`ifdef SIPO_PARITY_EN
            if (start) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = '0;
               w_clr       = 1'b1;
            end else if (si_valid) begin
               w_parity_err_nxt = (^w_po) ^ si;
               w_state_nxt      = ST_HOLD;
               w_po_valid_nxt   = 1'b1;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         ST_HOLD: begin
            // a bit arriving on the handshake cycle still counts as lost
            if (po_ready) begin
               w_po_valid_nxt = 1'b0;
               w_overrun_nxt  = si_valid;
               if (start) begin
                  w_state_nxt = ST_SHIFT;
                  w_cnt_nxt   = '0;
                  w_clr       = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (si_valid) begin
               w_overrun_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_po_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_po_valid <= w_po_valid_nxt;
         r_busy     <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_PARITY);
         r_overrun  <= w_overrun_nxt;
      end
   end

`ifdef SIPO_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_parity_err_nxt;
      end
   end
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign po       = w_po;
   assign po_valid = r_po_valid;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: directed frames then random traffic against a bit-queue reference model.
// Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_rx_ctrl;

   localparam int W = 8;
`ifdef SIPO_PARITY_EN
   localparam int NBITS = W + 1;
`else
   localparam int NBITS = W;
`endif

   logic         clk = 1'b0;
   logic         rst, start, si, si_valid, po_ready;
   logic [W-1:0] po;
   logic         po_valid, busy, overrun, parity_err;

   int n_vec = 0;
   int n_err = 0;

   // reference model: receiving flag, bits collected so far, and the held word
   bit          m_rx, m_have, m_ovr, m_perr, m_zero;
   int unsigned m_word;
   bit          m_q[$];

   sipo_rx_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .si        (si),
      .si_valid  (si_valid),
      .po        (po),
      .po_valid  (po_valid),
      .po_ready  (po_ready),
      .busy      (busy),
      .overrun   (overrun),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic finish_word();
      bit p;
      p      = 1'b0;
      m_word = 0;
      for (int i = 0; i < W; i++) m_word |= 32'(m_q[i]) << i;
      for (int i = 0; i < NBITS; i++) p ^= m_q[i];
      m_perr = p;
      m_rx   = 1'b0;
      m_have = 1'b1;
   endtask

   task automatic model(input bit st, input bit s, input bit sv, input bit rdy, input bit r);
      if (r) begin
         m_rx = 0; m_have = 0; m_ovr = 0; m_perr = 0; m_zero = 1;
         m_q.delete();
      end else if (m_have) begin
         if (rdy) begin
            m_have = 0;
            m_ovr  = sv;
            if (st) begin
               m_rx = 1; m_zero = 1;
               m_q.delete();
            end
         end else if (sv) begin
            m_ovr = 1;
         end
      end else if (m_rx) begin
         if (st) begin
            m_q.delete();
            m_zero = 1;
         end else if (sv) begin
            m_q.push_back(s);
            m_zero = 0;
            if (m_q.size() == NBITS) finish_word();
         end
      end else if (st) begin
         m_rx = 1; m_zero = 1;
         m_q.delete();
      end
   endtask

   task automatic check_outputs();
      chk("po_valid", {31'd0, po_valid}, {31'd0, m_have});
      chk("busy", {31'd0, busy}, {31'd0, m_rx});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef SIPO_PARITY_EN
      if (m_have) chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
`else
      chk("parity_err", {31'd0, parity_err}, 32'd0);
`endif
      if (m_have)      chk("po", 32'(po), m_word);
      else if (m_zero) chk("po_clear", 32'(po), 32'd0);
   endtask

   task automatic tick(input bit st, input bit s, input bit sv, input bit rdy, input bit r);
      start = st; si = s; si_valid = sv; po_ready = rdy; rst = r;
      @(posedge clk);
      model(st, s, sv, rdy, r);
      #1;
      check_outputs();
   endtask

   // data bits LSB first with gap idle cycles between them, then the parity bit if built in
   task automatic send_word(input logic [31:0] w, input int gap, input bit rdy, input bit bad_par);
      for (int i = 0; i < W; i++) begin
         tick(0, w[i], 1, rdy, 0);
         if (i < NBITS - 1) repeat (gap) tick(0, 0, 0, rdy, 0);
      end
`ifdef SIPO_PARITY_EN
      tick(0, (^w[W-1:0]) ^ bad_par, 1, rdy, 0);
`else
      if (bad_par) tick(0, 0, 0, rdy, 0);
`endif
   endtask

   initial begin
      tick(0, 0, 0, 0, 1);
      tick(1, 1, 1, 1, 1);
      tick(0, 1, 1, 0, 0);

      // back-to-back bits, consumer always ready
      tick(1, 0, 0, 1, 0);
      send_word(32'h4D, 0, 1, 0);
      chk("word_4D", 32'(po), 32'h4D);
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 0);
      chk("busy_after", {31'd0, busy}, 32'd0);

      // 3-cycle gaps between bits
      tick(1, 0, 0, 0, 0);
      send_word(32'h4D, 3, 0, 0);
      chk("word_4D_gap", 32'(po), 32'h4D);
      tick(0, 0, 0, 1, 0);

      // held word with two dropped bits, then release
      tick(1, 0, 0, 0, 0);
      send_word(32'h3C, 0, 0, 0);
      tick(0, 1, 1, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      chk("ovr_po", 32'(po), 32'h3C);
      tick(0, 0, 0, 1, 0);
      chk("ovr_clr", {31'd0, overrun}, 32'd0);

      // reset mid-frame, then a clean frame
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 0);
      tick(0, 1, 1, 1, 1);
      tick(1, 0, 0, 0, 0);
      send_word(32'h96, 1, 0, 0);
      chk("word_96", 32'(po), 32'h96);
      tick(0, 0, 0, 1, 0);

      // restart after 3 bits
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0);
      tick(1, 1, 1, 0, 0);
      send_word(32'hA5, 0, 0, 0);
      chk("word_A5", 32'(po), 32'hA5);
      // start together with ready goes straight into a new frame
      tick(1, 0, 0, 1, 0);
      send_word(32'h4D, 0, 0, 1);
`ifdef SIPO_PARITY_EN
      chk("perr_bad", {31'd0, parity_err}, 32'd1);
`else
      chk("perr_off", {31'd0, parity_err}, 32'd0);
`endif
      chk("word_4D_b2b", 32'(po), 32'h4D);
      tick(0, 0, 0, 1, 0);

      for (int n = 0; n < 3000; n++) begin
         tick($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
